// File: rtl/char_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : char_buffer_ctrl
// Description : Write sequencer for the 80x25 character buffer RAM. Executes
//               one VT52 decoder command at a time (put char, clear to end of
//               line, clear to end of screen, scroll up). While scrolling it
//               borrows the RAM's registered read port through a
//               request/grant pair shared with video scan-out.
// Revision    : 1.0 - initial release
// ============================================================================
module char_buffer_ctrl #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 25,
    parameter int         ADDR_W = 11,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_char,
    input  logic [4:0]        cmd_row,
    input  logic [6:0]        cmd_col,

    output logic              busy,
    output logic              done,
    output logic              err,

    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,

    output logic              rd_req,
    input  logic              rd_gnt,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data
);

    // Command opcodes
    localparam logic [1:0] c_OP_PUT    = 2'd0;
    localparam logic [1:0] c_OP_EOL    = 2'd1;
    localparam logic [1:0] c_OP_EOS    = 2'd2;
    localparam logic [1:0] c_OP_SCROLL = 2'd3;

    // Geometry constants at the widths they are compared against
    localparam logic [4:0]        c_ROWS      = 5'(ROWS);
    localparam logic [6:0]        c_COLS      = 7'(COLS);
    localparam logic [ADDR_W-1:0] c_COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_COLS_M1   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ROW  = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUT   = 3'd1,
        S_FILL  = 3'd2,
        S_MOVE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t              state_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q;
    logic                done_q;
    logic                err_q;
    logic                rd_req_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [ADDR_W-1:0]   k_q;          // destination index of the next scroll read
    logic [ADDR_W-1:0]   fill_end_q;   // last address of the current blank fill
    logic                from_ram_q;   // presented write carries RAM read data

    logic [ADDR_W-1:0]   row_base_d;
    logic [ADDR_W-1:0]   start_d;
    logic [ADDR_W-1:0]   eol_d;
    logic                range_err_d;

    // Target address decode for the command on the input bus
    always_comb begin
        row_base_d  = ADDR_W'(cmd_row) * c_COLS_A;
        start_d     = row_base_d + ADDR_W'(cmd_col);
        eol_d       = row_base_d + c_COLS_M1;
        range_err_d = (cmd_row >= c_ROWS) || (cmd_col >= c_COLS);
    end

    // Command sequencer; all outputs except scroll write data are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            k_q        <= '0;
            fill_end_q <= '0;
            from_ram_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    wr_en_q    <= 1'b0;
                    from_ram_q <= 1'b0;
                    if (cmd_valid) begin
                        if (cmd_op == c_OP_SCROLL) begin
                            // First source row starts one row below the top
                            state_q   <= S_MOVE;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= c_COLS_A;
                            k_q       <= '0;
                        end else if (range_err_d) begin
                            // Dropped command: flag it and stay idle
                            err_q <= 1'b1;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= start_d;
                            case (cmd_op)
                                c_OP_PUT: begin
                                    wr_data_q <= cmd_char;
                                    done_q    <= 1'b1;
                                    state_q   <= S_PUT;
                                end
                                c_OP_EOL: begin
                                    wr_data_q  <= BLANK;
                                    fill_end_q <= eol_d;
                                    done_q     <= (start_d == eol_d);
                                    state_q    <= S_FILL;
                                end
                                default: begin
                                    wr_data_q  <= BLANK;
                                    fill_end_q <= c_LAST;
                                    done_q     <= (start_d == c_LAST);
                                    state_q    <= S_FILL;
                                end
                            endcase
                        end
                    end
                end

                S_PUT: begin
                    wr_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end

                S_FILL: begin
                    if (wr_addr_q == fill_end_q) begin
                        wr_en_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wr_addr_q <= wr_addr_q + c_ONE;
                        done_q    <= ((wr_addr_q + c_ONE) == fill_end_q);
                    end
                end

                S_MOVE: begin
                    // A grant this cycle means RAM data arrives next cycle,
                    // so the matching write is presented then.
                    wr_en_q    <= rd_gnt;
                    from_ram_q <= rd_gnt;
                    wr_addr_q  <= k_q;
                    if (rd_gnt) begin
                        k_q <= k_q + c_ONE;
                        if (rd_addr_q == c_LAST) begin
                            rd_req_q  <= 1'b0;
                            rd_addr_q <= '0;
                            state_q   <= S_DRAIN;
                        end else begin
                            rd_addr_q <= rd_addr_q + c_ONE;
                        end
                    end
                end

                S_DRAIN: begin
                    // Last moved character is written this cycle; blank the
                    // bottom row next.
                    from_ram_q <= 1'b0;
                    wr_en_q    <= 1'b1;
                    wr_addr_q  <= c_LAST_ROW;
                    wr_data_q  <= BLANK;
                    fill_end_q <= c_LAST;
                    done_q     <= (c_LAST_ROW == c_LAST);
                    state_q    <= S_FILL;
                end

                default: begin
                    state_q    <= S_IDLE;
                    wr_en_q    <= 1'b0;
                    rd_req_q   <= 1'b0;
                    from_ram_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; scroll data passes straight from the RAM's output
    // register since it only becomes valid in the write cycle itself.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = done_q;
        err       = err_q;
        wr_en     = wr_en_q;
        wr_addr   = wr_addr_q;
        wr_data   = from_ram_q ? rd_data : wr_data_q;
        rd_req    = rd_req_q;
        rd_addr   = rd_addr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_char_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_buffer_ctrl
// Description : Self-checking bench for char_buffer_ctrl with a RAM model and
//               a screen-level reference model of the buffer contents.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_char_buffer_ctrl;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 25;
    localparam int         N     = ROWS * COLS;
    localparam int         AW    = 11;
    localparam logic [7:0] BLANK = 8'h20;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op    = 2'd0;
    logic [7:0]    cmd_char  = 8'd0;
    logic [4:0]    cmd_row   = 5'd0;
    logic [6:0]    cmd_col   = 7'd0;
    logic          busy, done, err;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_req;
    logic          rd_gnt    = 1'b1;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data   = 8'd0;

    char_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .BLANK(BLANK)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_char(cmd_char), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .busy(busy), .done(done), .err(err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mem     [0:N-1];
    logic [7:0] ref_mem [0:N-1];

    // Per-command observations
    int  t_acc;
    int  n_wr, first_wr_cyc, first_wr_addr, first_wr_data, last_wr_addr;
    int  done_cnt, done_cyc, done_addr, done_wr;
    int  err_cnt, err_cyc, nonblank, idle_act, orphan, missing, bad_pair;
    int  wr_after_done, ready_busy_bad, n_gread, ready_cyc;
    bit  in_scroll = 0;
    bit  gnt_rand  = 0;
    bit  gnt_prev  = 0;
    int  prev_rd_addr = 0;

    always @(posedge clk) cyc++;

    // RAM model: write port, then registered read port
    always @(posedge clk) begin
        if (wr_en && int'(wr_addr) < N) mem[wr_addr] = wr_data;
        gnt_prev     = rd_req && rd_gnt;
        prev_rd_addr = int'(rd_addr);
        if (rd_req && rd_gnt) begin
            n_gread++;
            if (int'(rd_addr) < N) rd_data = mem[rd_addr];
        end
    end

    // Scan-out arbiter stand-in
    always @(posedge clk) begin
        #2;
        rd_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (n_wr == 0) begin
                    first_wr_cyc  = cyc;
                    first_wr_addr = int'(wr_addr);
                    first_wr_data = int'(wr_data);
                end
                n_wr++;
                last_wr_addr = int'(wr_addr);
                if (wr_data != BLANK) nonblank++;
                if (done_cnt > 0) wr_after_done++;
                if (in_scroll && !gnt_prev && int'(wr_addr) < N - COLS) orphan++;
                if (gnt_prev && int'(wr_addr) != prev_rd_addr - COLS) bad_pair++;
            end
            if (gnt_prev && !wr_en) missing++;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_addr = int'(wr_addr);
                done_wr   = int'(wr_en);
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (cmd_ready && (wr_en || rd_req)) idle_act++;
            if (!in_scroll && rd_req) idle_act++;
            if (cmd_ready == busy) ready_busy_bad++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic clear_stats();
        n_wr = 0; first_wr_cyc = -1; first_wr_addr = -1; first_wr_data = -1;
        last_wr_addr = -1; done_cnt = 0; done_cyc = -1; done_addr = -1; done_wr = 0;
        err_cnt = 0; err_cyc = -1; nonblank = 0; idle_act = 0; orphan = 0;
        missing = 0; bad_pair = 0; wr_after_done = 0; ready_busy_bad = 0;
        n_gread = 0; ready_cyc = -1;
    endtask

    // Screen-level effect of a command on the reference buffer
    task automatic model_apply(input int op, input int row, input int col, input logic [7:0] ch);
        int a;
        a = row * COLS + col;
        case (op)
            0: ref_mem[a] = ch;
            1: for (int c = col; c < COLS; c++) ref_mem[row * COLS + c] = BLANK;
            2: for (int i = a; i < N; i++) ref_mem[i] = BLANK;
            default: begin
                for (int i = 0; i < N - COLS; i++) ref_mem[i] = ref_mem[i + COLS];
                for (int i = N - COLS; i < N; i++) ref_mem[i] = BLANK;
            end
        endcase
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    task automatic preload(input bit random_fill);
        for (int i = 0; i < N; i++) begin
            mem[i]     = random_fill ? 8'($urandom) : 8'(i);
            ref_mem[i] = mem[i];
        end
    endtask

    task automatic issue(input logic [1:0] op, input int row, input int col, input logic [7:0] ch);
        @(posedge clk); #2;
        clear_stats();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = 5'(row);
        cmd_col   = 7'(col);
        cmd_char  = ch;
        t_acc     = cyc;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_ready && cyc > t_acc) begin
                ok = 1;
                ready_cyc = cyc;
                break;
            end
        end
        chk1(tag, ok, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int row, col, a;
        logic [7:0] ch;
        bit found;

        preload(0);
        #1 reset = 1'b1;
        #2;
        chk1("rst_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_wr_en", wr_en, 1'b0);
        chk1("rst_rd_req", rd_req, 1'b0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        @(posedge clk); #2 reset = 1'b0;

        // Directed PUT
        issue(2'd0, 2, 5, 8'h41);
        model_apply(0, 2, 5, 8'h41);
        wait_idle(20, "put_timeout");
        chk("put_nwr", n_wr, 1);
        chk("put_addr", first_wr_addr, 165);
        chk("put_data", first_wr_data, 8'h41);
        chk("put_wr_cyc", first_wr_cyc, t_acc + 1);
        chk("put_done_cyc", done_cyc, t_acc + 1);
        chk("put_ready_cyc", ready_cyc, t_acc + 2);

        // Random PUTs
        for (int n = 0; n < 6; n++) begin
            row = $urandom_range(0, ROWS - 1);
            col = $urandom_range(0, COLS - 1);
            ch  = 8'($urandom);
            issue(2'd0, row, col, ch);
            model_apply(0, row, col, ch);
            wait_idle(20, "rput_timeout");
            chk("rput_nwr", n_wr, 1);
            chk("rput_addr", first_wr_addr, row * COLS + col);
            chk("rput_data", first_wr_data, int'(ch));
            chk("rput_done", done_cnt * 10000 + done_cyc, 10000 + t_acc + 1);
        end
        chk("put_mem", mem_diffs(), 0);

        // CLR_EOL at the very end of the screen
        issue(2'd1, 24, 78, 8'h00);
        model_apply(1, 24, 78, 8'h00);
        wait_idle(20, "eol_timeout");
        chk("eol_nwr", n_wr, 2);
        chk("eol_first", first_wr_addr, 1998);
        chk("eol_last", last_wr_addr, 1999);
        chk("eol_done_addr", done_addr, 1999);
        chk("eol_done_cnt", done_cnt, 1);
        chk("eol_nonblank", nonblank, 0);

        // Random CLR_EOLs
        for (int n = 0; n < 3; n++) begin
            row = $urandom_range(0, ROWS - 1);
            col = $urandom_range(0, COLS - 1);
            issue(2'd1, row, col, 8'h00);
            model_apply(1, row, col, 8'h00);
            wait_idle(200, "reol_timeout");
            chk("reol_nwr", n_wr, COLS - col);
            chk("reol_done_cyc", done_cyc, t_acc + COLS - col);
            chk("reol_last", last_wr_addr, row * COLS + COLS - 1);
        end
        chk("eol_mem", mem_diffs(), 0);

        // Out-of-range commands are dropped
        issue(2'd0, 3, 80, 8'h55);
        repeat (4) @(negedge clk);
        chk("oor_col_err", err_cnt, 1);
        chk("oor_col_err_cyc", err_cyc, t_acc + 1);
        chk("oor_col_nwr", n_wr, 0);
        chk("oor_col_done", done_cnt, 0);
        chk1("oor_col_ready", cmd_ready, 1'b1);
        issue(2'd2, 25, 0, 8'h00);
        repeat (4) @(negedge clk);
        chk("oor_row_err", err_cnt, 1);
        chk("oor_row_nwr", n_wr, 0);
        chk("oor_mem", mem_diffs(), 0);

        // SCROLL with a permanent grant
        preload(0);
        in_scroll = 1;
        issue(2'd3, 0, 0, 8'h00);
        model_apply(3, 0, 0, 8'h00);
        wait_idle(2200, "scr_timeout");
        in_scroll = 0;
        chk("scr_first_wr", first_wr_cyc, t_acc + 2);
        chk("scr_done_cyc", done_cyc, t_acc + 2001);
        chk("scr_done_addr", done_addr, N - 1);
        chk("scr_nwr", n_wr, N);
        chk("scr_gread", n_gread, N - COLS);
        chk("scr_pairing", orphan + missing + bad_pair, 0);
        chk("scr_mem", mem_diffs(), 0);

        // SCROLL with a toggling grant over random contents
        preload(1);
        gnt_rand  = 1;
        in_scroll = 1;
        issue(2'd3, 0, 0, 8'h00);
        model_apply(3, 0, 0, 8'h00);
        wait_idle(12000, "rscr_timeout");
        in_scroll = 0;
        gnt_rand  = 0;
        chk("rscr_nwr", n_wr, N);
        chk("rscr_gread", n_gread, N - COLS);
        chk("rscr_orphan", orphan, 0);
        chk("rscr_missing", missing, 0);
        chk("rscr_pair", bad_pair, 0);
        chk("rscr_done", done_cnt * 10000 + done_addr, 10000 + N - 1);
        chk("rscr_mem", mem_diffs(), 0);

        // Full-screen clear
        issue(2'd2, 0, 0, 8'h00);
        model_apply(2, 0, 0, 8'h00);
        wait_idle(2200, "eos_timeout");
        chk("eos_nwr", n_wr, N);
        chk("eos_first", first_wr_addr, 0);
        chk("eos_last", last_wr_addr, N - 1);
        chk("eos_done_cnt", done_cnt, 1);
        chk("eos_done_cyc", done_cyc, t_acc + N);
        chk("eos_nonblank", nonblank, 0);
        chk("eos_mem", mem_diffs(), 0);

        // Partial clear from a random position
        preload(1);
        row = $urandom_range(0, ROWS - 1);
        col = $urandom_range(0, COLS - 1);
        a   = row * COLS + col;
        issue(2'd2, row, col, 8'h00);
        model_apply(2, row, col, 8'h00);
        wait_idle(2200, "reos_timeout");
        chk("reos_nwr", n_wr, N - a);
        chk("reos_done_cyc", done_cyc, t_acc + N - a);
        chk("reos_mem", mem_diffs(), 0);

        // Session-wide bus rules
        chk("idle_activity", idle_act, 0);
        chk("wr_after_done", wr_after_done, 0);
        chk("ready_vs_busy", ready_busy_bad, 0);

        // Reset in the middle of a full-screen clear
        preload(0);
        issue(2'd2, 0, 0, 8'h00);
        found = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == AW'(500)) begin
                found = 1;
                break;
            end
        end
        chk1("abort_reach_500", found, 1'b1);
        reset = 1'b1;
        #1;
        chk1("abort_wr_en", wr_en, 1'b0);
        chk1("abort_ready", cmd_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        for (int i = 0; i < 500; i++) ref_mem[i] = BLANK;
        @(posedge clk); #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_mem", mem_diffs(), 0);

        // Controller is usable again after the abort
        issue(2'd0, 24, 79, 8'h7e);
        model_apply(0, 24, 79, 8'h7e);
        wait_idle(20, "post_timeout");
        chk("post_nwr", n_wr, 1);
        chk("post_mem", mem_diffs(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
